// File: rtl/common_pkg.sv
// Shared helpers for elaboration-time parameter sanity checks.
// Functions are constant-evaluable so generate blocks can call them.
package common_pkg;

   // True when v is a strictly positive count (widths, depths >= 1).
   function automatic bit check_param_pos(input int v);
      return (v >= 1);
   endfunction

   // True when v is a non-negative count (latencies, optional stages).
   function automatic bit check_param_nonneg(input int v);
      return (v >= 0);
   endfunction

   // True when lo <= v <= hi.
   function automatic bit check_param_range(
      input int v,
      input int lo,
      input int hi
   );
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/cxu_shift_reg.sv
// cxu_shift_reg: W-bit, N-stage delay line with clock enable.
// Ports: clk, rst (async, active-low), clk_en, d[W], q[W] (= d when N=0).
module cxu_shift_reg
   import common_pkg::*;
#(
   parameter int W = 1,
   parameter int N = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   if (!check_param_pos(W)) begin : g_bad_w
      $error("cxu_shift_reg: W must be >= 1");
   end

   if (!check_param_nonneg(N)) begin : g_bad_n
      $error("cxu_shift_reg: N must be >= 0");
   end

   if (N == 0) begin : g_wire
      // Zero latency: no state, control inputs intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, clk_en};
      assign q = d;

   end else if (N == 1) begin : g_one
      logic [W-1:0] s_q;
      logic [W-1:0] s_d;

      always_comb begin
         s_d = s_q;
         if (clk_en) begin
            s_d = d;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s_q <= '0;
         end else begin
            s_q <= s_d;
         end
      end

      assign q = s_q;

   end else begin : g_many
      // Stage 0 sits in the low slice; the oldest value in the top slice.
      logic [N-1:0][W-1:0] s_q;
      logic [N-1:0][W-1:0] s_d;

      always_comb begin
         s_d = s_q;
         if (clk_en) begin
            s_d = {s_q[N-2:0], d};
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s_q <= '0;
         end else begin
            s_q <= s_d;
         end
      end

      assign q = s_q[N-1];
   end

endmodule

// File: tb/tb_cxu_shift_reg.sv
// Self-checking bench for cxu_shift_reg across several W/N shapes.
// Expected values come from arithmetic and queue-based models.
module tb_cxu_shift_reg;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // A: W=8 N=3
   logic       rst_a = 1'b1;
   logic       en_a  = 1'b0;
   logic [7:0] d_a   = '0;
   logic [7:0] q_a;
   // B: W=8 N=2
   logic       rst_b = 1'b1;
   logic       en_b  = 1'b0;
   logic [7:0] d_b   = '0;
   logic [7:0] q_b;
   // C: W=4 N=4
   logic       rst_c = 1'b1;
   logic       en_c  = 1'b0;
   logic [3:0] d_c   = '0;
   logic [3:0] q_c;
   // D: W=16 N=0
   logic        rst_d = 1'b1;
   logic        en_d  = 1'b0;
   logic [15:0] d_d   = '0;
   logic [15:0] q_d;
   // E: W=1 N=1
   logic rst_e = 1'b1;
   logic en_e  = 1'b0;
   logic d_e   = 1'b0;
   logic q_e;

   cxu_shift_reg #(.W(8), .N(3)) u_a (
      .clk(clk), .rst(rst_a), .clk_en(en_a), .d(d_a), .q(q_a));
   cxu_shift_reg #(.W(8), .N(2)) u_b (
      .clk(clk), .rst(rst_b), .clk_en(en_b), .d(d_b), .q(q_b));
   cxu_shift_reg #(.W(4), .N(4)) u_c (
      .clk(clk), .rst(rst_c), .clk_en(en_c), .d(d_c), .q(q_c));
   cxu_shift_reg #(.W(16), .N(0)) u_d (
      .clk(clk), .rst(rst_d), .clk_en(en_d), .d(d_d), .q(q_d));
   cxu_shift_reg #(.W(1), .N(1)) u_e (
      .clk(clk), .rst(rst_e), .clk_en(en_e), .d(d_e), .q(q_e));

   // Advance to 1 time unit after the next rising edge.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      rst_e = 1'b0;
      #1;
      checks++;
      if (q_a !== 8'h00) begin
         errors++;
         $display("FAIL reset_a got %h want 00", q_a);
      end
      checks++;
      if (q_e !== 1'b0) begin
         errors++;
         $display("FAIL reset_e got %b want 0", q_e);
      end
      d_a  = 8'hAA;
      en_a = 1'b1;
      for (int i = 0; i < 5; i++) begin
         edge1();
         checks++;
         if (q_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold[%0d] got %h want 00", i, q_a);
         end
      end
      rst_a = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         edge1();
         checks++;
         if (q_a !== ((i == 3) ? 8'hAA : 8'h00)) begin
            errors++;
            $display("FAIL reset_release[%0d] got %h want %h",
                     i, q_a, (i == 3) ? 8'hAA : 8'h00);
         end
      end
   endtask

   task automatic test_latency();
      logic [7:0] exp;
      rst_a = 1'b0;
      #1;
      rst_a = 1'b1;
      en_a  = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         d_a = (i <= 5) ? 8'(i) : 8'h00;
         edge1();
         exp = (i >= 3 && i - 2 <= 5) ? 8'(i - 2) : 8'h00;
         checks++;
         if (q_a !== exp) begin
            errors++;
            $display("FAIL latency[%0d] got %h want %h", i, q_a, exp);
         end
      end
   endtask

   task automatic test_clk_en();
      rst_b = 1'b0;
      #1;
      rst_b = 1'b1;
      en_b  = 1'b1;
      d_b   = 8'h11;
      edge1();
      d_b = 8'h22;
      edge1();
      checks++;
      if (q_b !== 8'h11) begin
         errors++;
         $display("FAIL en_load got %h want 11", q_b);
      end
      en_b = 1'b0;
      d_b  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         edge1();
         checks++;
         if (q_b !== 8'h11) begin
            errors++;
            $display("FAIL en_hold[%0d] got %h want 11", i, q_b);
         end
      end
      en_b = 1'b1;
      edge1();
      checks++;
      if (q_b !== 8'h22) begin
         errors++;
         $display("FAIL en_resume0 got %h want 22", q_b);
      end
      edge1();
      checks++;
      if (q_b !== 8'hFF) begin
         errors++;
         $display("FAIL en_resume1 got %h want ff", q_b);
      end
   endtask

   task automatic test_async_reset();
      rst_c = 1'b1;
      en_c  = 1'b1;
      d_c   = 4'hF;
      for (int i = 0; i < 4; i++) edge1();
      checks++;
      if (q_c !== 4'hF) begin
         errors++;
         $display("FAIL async_fill got %h want f", q_c);
      end
      #2;
      rst_c = 1'b0;
      #1;
      checks++;
      if (q_c !== 4'h0) begin
         errors++;
         $display("FAIL async_now got %h want 0", q_c);
      end
      for (int i = 0; i < 3; i++) begin
         edge1();
         checks++;
         if (q_c !== 4'h0) begin
            errors++;
            $display("FAIL async_hold[%0d] got %h want 0", i, q_c);
         end
      end
      rst_c = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         edge1();
         checks++;
         if (q_c !== ((i == 4) ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL async_refill[%0d] got %h want %h",
                     i, q_c, (i == 4) ? 4'hF : 4'h0);
         end
      end
   endtask

   task automatic test_passthrough();
      logic [15:0] pat [4];
      pat[0] = 16'h1234;
      pat[1] = 16'hBEEF;
      pat[2] = 16'h1234;
      pat[3] = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         rst_d = (i >= 2) ? 1'b0 : 1'b1;
         en_d  = i[0];
         d_d   = pat[i];
         #1;
         checks++;
         if (q_d !== pat[i]) begin
            errors++;
            $display("FAIL pass[%0d] got %h want %h", i, q_d, pat[i]);
         end
      end
      rst_d = 1'b1;
   endtask

   task automatic test_valid_bit();
      logic seq_d  [5];
      logic seq_en [5];
      logic seq_q  [5];
      seq_d[0] = 1'b1; seq_en[0] = 1'b1; seq_q[0] = 1'b1;
      seq_d[1] = 1'b0; seq_en[1] = 1'b1; seq_q[1] = 1'b0;
      seq_d[2] = 1'b1; seq_en[2] = 1'b0; seq_q[2] = 1'b0;
      seq_d[3] = 1'b1; seq_en[3] = 1'b1; seq_q[3] = 1'b1;
      seq_d[4] = 1'b0; seq_en[4] = 1'b0; seq_q[4] = 1'b1;
      rst_e = 1'b1;
      checks++;
      if (q_e !== 1'b0) begin
         errors++;
         $display("FAIL valid_init got %b want 0", q_e);
      end
      for (int i = 0; i < 5; i++) begin
         d_e  = seq_d[i];
         en_e = seq_en[i];
         edge1();
         checks++;
         if (q_e !== seq_q[i]) begin
            errors++;
            $display("FAIL valid[%0d] got %b want %b", i, q_e, seq_q[i]);
         end
      end
   endtask

   // Random traffic on A (N=3) and B (N=2); models are queues of the
   // last N accepted values, newest at the front.
   task automatic test_random();
      logic [7:0] ma[$];
      logic [7:0] mb[$];
      int         bad_a;
      int         bad_b;
      bad_a = 0;
      bad_b = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      #1;
      ma = '{8'h00, 8'h00, 8'h00};
      mb = '{8'h00, 8'h00};
      for (int i = 0; i < 300; i++) begin
         rst_a = ($urandom_range(0, 24) != 0);
         rst_b = ($urandom_range(0, 24) != 0);
         en_a  = $urandom_range(0, 3) != 0;
         en_b  = $urandom_range(0, 1) != 0;
         d_a   = 8'($urandom);
         d_b   = 8'($urandom);
         if (!rst_a) ma = '{8'h00, 8'h00, 8'h00};
         if (!rst_b) mb = '{8'h00, 8'h00};
         #1;
         checks++;
         if (q_a !== ma[2]) begin
            errors++;
            if (bad_a++ < 5)
               $display("FAIL rand_a_pre[%0d] got %h want %h", i, q_a, ma[2]);
         end
         edge1();
         if (rst_a && en_a) begin
            ma.push_front(d_a);
            void'(ma.pop_back());
         end
         if (rst_b && en_b) begin
            mb.push_front(d_b);
            void'(mb.pop_back());
         end
         checks++;
         if (q_a !== ma[2]) begin
            errors++;
            if (bad_a++ < 5)
               $display("FAIL rand_a[%0d] got %h want %h", i, q_a, ma[2]);
         end
         checks++;
         if (q_b !== mb[1]) begin
            errors++;
            if (bad_b++ < 5)
               $display("FAIL rand_b[%0d] got %h want %h", i, q_b, mb[1]);
         end
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
   endtask

   initial begin
      #1;
      test_reset();
      test_latency();
      test_clk_en();
      test_async_reset();
      test_passthrough();
      test_valid_bit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
